// File: rtl/wb_regfile_writer_pkg.sv
// Shared write-back encodings for the RV32 pipeline.
// Holds the wb_sel source codes and load funct3 codes used by the decoder, MEM and WB.
package wb_regfile_writer_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/wb_regfile_writer_load_extend.sv
// Load data extraction: picks a byte/halfword from an aligned word and extends it.
// Ports: word (raw aligned word), addr (low address bits), funct3 (width/sign), result.
module load_extend
  import wb_regfile_writer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    unique case (addr)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  // Halfword offset uses addr[1] only; addr[0] is ignored.
  assign half_sel = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = word;
    unique case (funct3)
      FUNCT3_LB:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      FUNCT3_LBU: result = {{(XLEN-8){1'b0}}, byte_sel};
      FUNCT3_LH:  result = {{(XLEN-16){half_sel[15]}}, half_sel};
      FUNCT3_LHU: result = {{(XLEN-16){1'b0}}, half_sel};
      default:    result = word;
    endcase
  end

endmodule

// File: rtl/wb_regfile_writer.sv
// Write-back stage: MEM/WB register, source select, x0 suppression, instret.
// Ports: mem_* from MEM, stall/flush control, WE/waddr/wdata to RegFile, retire/instret.
module wb_regfile_writer
  import wb_regfile_writer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wb_sel,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_word,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  input  logic             stall,
  input  logic             flush,
  output logic             WE,
  output logic [4:0]       waddr,
  output logic [XLEN-1:0]  wdata,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);

  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            rw_q, rw_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] cap_data;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .word   (mem_load_word),
    .addr   (mem_alu_result[1:0]),
    .funct3 (mem_funct3),
    .result (load_data)
  );

  always_comb begin
    cap_data = mem_alu_result;
    unique case (mem_wb_sel)
      WB_SEL_LOAD: cap_data = load_data;
      WB_SEL_PC4:  cap_data = mem_pc_plus4;
      default:     cap_data = mem_alu_result;
    endcase
  end

  // Stall holds the entry; done marks that its single write already happened.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    rw_d    = rw_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (stall) begin
      if (valid_q) done_d = 1'b1;
    end else if (flush) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else begin
      valid_d = mem_valid;
      done_d  = 1'b0;
      rw_d    = mem_reg_write;
      rd_d    = mem_rd;
      data_d  = cap_data;
    end
  end

  // Outputs are gated by rst_n so nothing leaks out while reset is held.
  assign retire = rst_n & valid_q & ~done_q;
  assign WE     = retire & rw_q & (rd_q != 5'd0);
  assign waddr  = WE ? rd_q : 5'd0;
  assign wdata  = WE ? data_q : '0;

  assign instret_d = instret_q + CNT_W'(retire);
  assign instret   = instret_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      rw_q      <= 1'b0;
      rd_q      <= 5'd0;
      data_q    <= '0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      done_q    <= done_d;
      rw_q      <= rw_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      instret_q <= instret_d;
    end
  end

endmodule
